// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX-side request, data-memory bus and MEM_WB-side
// result of the memory stage. The master modport is the stage itself, and
// the slave modport is its environment (EX, memory and MEM_WB together).
interface mem_stage_if;
  // EX side
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode_i;
  logic [7:0] alu_reg_i;
  logic [7:0] data1_i;
  logic [2:0] regD_i;
  logic       writeReg_i;
  // data memory
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  // MEM_WB side
  logic       out_valid;
  logic [7:0] alu_reg_o;
  logic [7:0] meDat_o;
  logic [2:0] regD_o;
  logic       writeReg_o;
  logic [3:0] opcode_o;
  logic       err;

  modport master (
    input  in_valid, opcode_i, alu_reg_i, data1_i, regD_i, writeReg_i,
    input  mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output out_valid, alu_reg_o, meDat_o, regD_o, writeReg_o, opcode_o, err
  );

  modport slave (
    output in_valid, opcode_i, alu_reg_i, data1_i, regD_i, writeReg_i,
    output mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  out_valid, alu_reg_o, meDat_o, regD_o, writeReg_o, opcode_o, err
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Non-memory ops pass through in one cycle;
// LOAD/STORE issue a data-memory request and wait for mem_ack.
// Optional feature: define MEM_STAGE_TIMEOUT_EN to abort an access after
// TIMEOUT waiting cycles (result 8'hFF, sticky err).
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.master bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t     state, state_nx;
  logic       is_mem, accept, done_ack, tmo, done;
  logic [3:0] lat_op;
  logic [2:0] lat_rd;
  logic       lat_wr;

  // LOAD = 1000, STORE = 1001; bit 0 separates them
  assign is_mem      = (bus.opcode_i[3:1] == 3'b100);
  assign bus.in_ready = (state == S_IDLE);
  assign accept      = (state == S_IDLE) && bus.in_valid;
  // mem_req is high for the whole of WAIT, so sampling ack only there is enough
  assign done_ack    = (state == S_WAIT) && bus.mem_ack;
  assign done        = done_ack | tmo;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] cnt;
  // completion fires on the edge where the count would reach TIMEOUT;
  // an ack in the same cycle takes priority
  assign tmo = (state == S_WAIT) && !bus.mem_ack && (cnt == 8'(TIMEOUT - 1));

  // wait-cycle counter: cleared on WAIT entry, counts ack-less WAIT cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (accept && is_mem)     cnt <= '0;
    else if (state == S_WAIT && !bus.mem_ack) cnt <= cnt + 8'd1;
  end

  // sticky timeout flag, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   bus.err <= 1'b0;
    else if (tmo) bus.err <= 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^8'(TIMEOUT);
  assign tmo        = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && is_mem) state_nx = S_WAIT;
      S_WAIT: if (done)             state_nx = S_IDLE;
      default:                      state_nx = S_IDLE;
    endcase
  end

  // memory request, operand latch and registered MEM_WB outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.out_valid  <= 1'b0;
      bus.writeReg_o <= 1'b0;
      bus.alu_reg_o  <= '0;
      bus.meDat_o    <= '0;
      bus.regD_o     <= '0;
      bus.opcode_o   <= '0;
      lat_op         <= '0;
      lat_rd         <= '0;
      lat_wr         <= 1'b0;
    end else begin
      // bubble by default; data outputs hold
      bus.out_valid  <= 1'b0;
      bus.writeReg_o <= 1'b0;
      if (accept && !is_mem) begin
        bus.out_valid  <= 1'b1;
        bus.alu_reg_o  <= bus.alu_reg_i;
        bus.regD_o     <= bus.regD_i;
        bus.writeReg_o <= bus.writeReg_i;
        bus.opcode_o   <= bus.opcode_i;
        bus.meDat_o    <= '0;
      end
      if (accept && is_mem) begin
        // mem_addr doubles as the latched ALU result for the completion
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.opcode_i[0];
        bus.mem_addr  <= bus.alu_reg_i;
        bus.mem_wdata <= bus.data1_i;
        lat_op        <= bus.opcode_i;
        lat_rd        <= bus.regD_i;
        lat_wr        <= bus.writeReg_i & ~bus.opcode_i[0];
      end
      if (done) begin
        bus.mem_req    <= 1'b0;
        bus.mem_we     <= 1'b0;
        bus.out_valid  <= 1'b1;
        bus.alu_reg_o  <= bus.mem_addr;
        bus.regD_o     <= lat_rd;
        bus.opcode_o   <= lat_op;
        bus.writeReg_o <= tmo ? 1'b0 : lat_wr;
        bus.meDat_o    <= tmo       ? 8'hFF :
                          lat_op[0] ? 8'h00 : bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] alu,
                       input logic [7:0] d1, input logic [2:0] rd, input logic wr);
    bus.in_valid   = v;
    bus.opcode_i   = op;
    bus.alu_reg_i  = alu;
    bus.data1_i    = d1;
    bus.regD_i     = rd;
    bus.writeReg_i = wr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    tick();
    tick();
    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_alu_reg_o", bus.alu_reg_o, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;

    // non-memory op, accepted on the first edge after release
    drive(1'b1, 4'b0010, 8'h3C, 8'h00, 3'd3, 1'b1);
    tick();
    chk("alu_out_valid", bus.out_valid, 1);
    chk("alu_alu_reg_o", bus.alu_reg_o, 8'h3C);
    chk("alu_regD_o", bus.regD_o, 3);
    chk("alu_writeReg_o", bus.writeReg_o, 1);
    chk("alu_meDat_o", bus.meDat_o, 0);
    chk("alu_opcode_o", bus.opcode_o, 4'b0010);
    chk("alu_mem_req", bus.mem_req, 0);
    // back-to-back non-memory op
    drive(1'b1, 4'b0011, 8'h55, 8'h00, 3'd5, 1'b0);
    tick();
    chk("b2b_out_valid", bus.out_valid, 1);
    chk("b2b_alu_reg_o", bus.alu_reg_o, 8'h55);
    chk("b2b_regD_o", bus.regD_o, 5);
    chk("b2b_writeReg_o", bus.writeReg_o, 0);
    // bubble, with a stray mem_ack in IDLE
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    tick();
    bus.mem_ack = 1'b0;
    chk("bub_out_valid", bus.out_valid, 0);
    chk("bub_writeReg_o", bus.writeReg_o, 0);
    chk("bub_alu_hold", bus.alu_reg_o, 8'h55);
    tick();
    chk("ack_idle_out_valid", bus.out_valid, 0);
    chk("ack_idle_mem_req", bus.mem_req, 0);

    // LOAD 0x10, ack in the third request cycle
    drive(1'b1, 4'b1000, 8'h10, 8'h00, 3'd2, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("ld_c1_mem_req", bus.mem_req, 1);
    chk("ld_c1_mem_we", bus.mem_we, 0);
    chk("ld_c1_mem_addr", bus.mem_addr, 8'h10);
    chk("ld_c1_in_ready", bus.in_ready, 0);
    chk("ld_c1_out_valid", bus.out_valid, 0);
    tick();
    chk("ld_c2_mem_req", bus.mem_req, 1);
    chk("ld_c2_in_ready", bus.in_ready, 0);
    tick();
    chk("ld_c3_mem_req", bus.mem_req, 1);
    chk("ld_c3_in_ready", bus.in_ready, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    chk("ld_done_mem_req", bus.mem_req, 0);
    chk("ld_done_out_valid", bus.out_valid, 1);
    chk("ld_done_meDat_o", bus.meDat_o, 8'hA5);
    chk("ld_done_alu_reg_o", bus.alu_reg_o, 8'h10);
    chk("ld_done_regD_o", bus.regD_o, 2);
    chk("ld_done_writeReg_o", bus.writeReg_o, 1);
    chk("ld_done_opcode_o", bus.opcode_o, 4'b1000);
    chk("ld_done_in_ready", bus.in_ready, 1);
    tick();
    chk("ld_after_out_valid", bus.out_valid, 0);
    chk("ld_after_meDat_hold", bus.meDat_o, 8'hA5);

    // STORE 0x20 <- 0x77, ack in the first request cycle
    drive(1'b1, 4'b1001, 8'h20, 8'h77, 3'd4, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("st_mem_we", bus.mem_we, 1);
    chk("st_mem_wdata", bus.mem_wdata, 8'h77);
    chk("st_mem_addr", bus.mem_addr, 8'h20);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h33;
    tick();
    bus.mem_ack = 1'b0;
    chk("st_done_out_valid", bus.out_valid, 1);
    chk("st_done_writeReg_o", bus.writeReg_o, 0);
    chk("st_done_meDat_o", bus.meDat_o, 0);
    chk("st_done_opcode_o", bus.opcode_o, 4'b1001);
    chk("st_done_mem_we", bus.mem_we, 0);

    // LOAD then ADD held upstream during WAIT
    drive(1'b1, 4'b1000, 8'h40, 8'h00, 3'd1, 1'b1);
    tick();
    drive(1'b1, 4'b0010, 8'h99, 8'h00, 3'd6, 1'b1);
    tick();
    chk("hold_out_valid", bus.out_valid, 0);
    chk("hold_in_ready", bus.in_ready, 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
    tick();
    bus.mem_ack = 1'b0;
    chk("hold_ld_out_valid", bus.out_valid, 1);
    chk("hold_ld_meDat_o", bus.meDat_o, 8'h5A);
    chk("hold_ld_regD_o", bus.regD_o, 1);
    chk("hold_ld_in_ready", bus.in_ready, 1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("hold_add_out_valid", bus.out_valid, 1);
    chk("hold_add_alu_reg_o", bus.alu_reg_o, 8'h99);
    chk("hold_add_regD_o", bus.regD_o, 6);
    chk("hold_add_meDat_o", bus.meDat_o, 0);
    tick();
    chk("hold_nodup_out_valid", bus.out_valid, 0);

    // reset pulsed mid-access
    drive(1'b1, 4'b1000, 8'h50, 8'h00, 3'd2, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("rw_mem_req_pre", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_mem_req_async", bus.mem_req, 0);
    chk("rw_mem_addr_async", bus.mem_addr, 0);
    chk("rw_in_ready_async", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_rel_out_valid", bus.out_valid, 0);
    chk("rw_rel_mem_req", bus.mem_req, 0);
    drive(1'b1, 4'b0001, 8'h0F, 8'h00, 3'd7, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("rw_next_out_valid", bus.out_valid, 1);
    chk("rw_next_alu_reg_o", bus.alu_reg_o, 8'h0F);
    chk("rw_next_regD_o", bus.regD_o, 7);

`ifdef MEM_STAGE_TIMEOUT_EN
    // ack in the fourth WAIT cycle wins over the timeout
    drive(1'b1, 4'b1000, 8'h70, 8'h00, 3'd5, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    tick();
    tick();
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h12;
    tick();
    bus.mem_ack = 1'b0;
    chk("race_out_valid", bus.out_valid, 1);
    chk("race_meDat_o", bus.meDat_o, 8'h12);
    chk("race_writeReg_o", bus.writeReg_o, 1);
    chk("race_err", bus.err, 0);
    // no ack: abort after four WAIT cycles
    drive(1'b1, 4'b1000, 8'h60, 8'h00, 3'd3, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_mem_req", bus.mem_req, 1);
      chk("to_wait_out_valid", bus.out_valid, 0);
    end
    tick();
    chk("to_out_valid", bus.out_valid, 1);
    chk("to_meDat_o", bus.meDat_o, 8'hFF);
    chk("to_writeReg_o", bus.writeReg_o, 0);
    chk("to_err", bus.err, 1);
    chk("to_mem_req", bus.mem_req, 0);
    tick();
    chk("to_err_sticky", bus.err, 1);
    chk("to_after_out_valid", bus.out_valid, 0);
`else
    // without the timeout feature WAIT persists until mem_ack
    drive(1'b1, 4'b1000, 8'h60, 8'h00, 3'd3, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nto_mem_req", bus.mem_req, 1);
      chk("nto_out_valid", bus.out_valid, 0);
      chk("nto_err", bus.err, 0);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hC3;
    tick();
    bus.mem_ack = 1'b0;
    chk("nto_done_out_valid", bus.out_valid, 1);
    chk("nto_done_meDat_o", bus.meDat_o, 8'hC3);
    chk("nto_done_err", bus.err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum wait cycles for mem_ack before abort (range 1..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  EX-side operation present.
REQ-005 in_ready  out  1  stage accepts the operation this cycle; combinational = (state==IDLE).
REQ-006 opcode_i  in  4  operation code; 4'b1000 = LOAD, 4'b1001 = STORE, others non-memory.
REQ-007 alu_reg_i  in  8  ALU result, used as memory address for LOAD/STORE.
REQ-008 data1_i  in  8  store data.
REQ-009 regD_i  in  3  destination register index.
REQ-010 writeReg_i  in  1  register-write request.
REQ-011 mem_req, mem_we  out  1 each  data-memory request and write strobe.
REQ-012 mem_addr, mem_wdata  out  8 each  memory address and write data.
REQ-013 mem_ack  in  1  memory completion, one-cycle pulse; mem_rdata  in  8  read data, valid with mem_ack.
REQ-014 out_valid  out  1  registered result valid toward MEM_WB.
REQ-015 alu_reg_o, meDat_o  out  8 each; regD_o  out  3; writeReg_o  out  1; opcode_o  out  4  registered results toward MEM_WB.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 FSM states IDLE and WAIT only; all outputs except in_ready are registered.
REQ-018 IDLE with in_valid and non-memory opcode: next edge out_valid=1, alu_reg_o/regD_o/writeReg_o/opcode_o = inputs, meDat_o=0; state stays IDLE (1-cycle latency, back-to-back ops accepted every cycle).
REQ-019 IDLE with in_valid and LOAD/STORE: latch operands; next edge mem_req=1, mem_we=(STORE), mem_addr=alu_reg_i, mem_wdata=data1_i; state WAIT; out_valid=0 that edge.
REQ-020 WAIT: mem_req, mem_we, mem_addr, mem_wdata held stable until the mem_ack cycle.
REQ-021 WAIT with mem_ack: next edge mem_req=0, mem_we=0, out_valid=1, latched fields presented, meDat_o=mem_rdata for LOAD, 0 for STORE; state IDLE.
REQ-022 STORE always presents writeReg_o=0 regardless of writeReg_i.
REQ-023 Any cycle without a result presented: out_valid=0 and writeReg_o=0 (bubble); other data outputs hold previous value.
REQ-024 in_valid while in WAIT is not accepted (in_ready=0); the upstream holds it; no operation lost or duplicated.
REQ-025 mem_ack in IDLE is ignored; out_valid never asserts from it.
REQ-026 mem_ack in the same cycle as entering WAIT (request edge) is not possible; mem_ack is sampled only while mem_req=1.

Reset
REQ-027 rst_n low: state IDLE; mem_req, mem_we, out_valid, writeReg_o, err = 0; mem_addr, mem_wdata, alu_reg_o, meDat_o, regD_o, opcode_o = 0; applies immediately, including mid-access (request abandoned).
REQ-028 First operation accepted at the first rising edge with rst_n high and in_valid=1.

Configuration
REQ-029 Macro MEM_STAGE_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry, increments each WAIT cycle without mem_ack; at count==TIMEOUT it completes as REQ-021 with meDat_o=8'hFF, writeReg_o=0, sets err=1 (cleared only by reset); mem_ack and timeout in the same cycle -> mem_ack wins, no error.
REQ-030 Macro undefined: no counter, WAIT persists indefinitely until mem_ack, err tied 0.

Verification
REQ-031 Non-memory op opcode=4'b0010, alu_reg_i=8'h3C, regD_i=3, writeReg_i=1 -> next edge out_valid=1, alu_reg_o=8'h3C, regD_o=3, writeReg_o=1, meDat_o=0.
REQ-032 LOAD addr 8'h10, mem_ack after 3 cycles with mem_rdata=8'hA5 -> mem_req high 3 cycles, in_ready=0 throughout, next edge meDat_o=8'hA5, out_valid=1 for exactly one cycle.
REQ-033 STORE addr 8'h20, data1_i=8'h77, writeReg_i=1 -> mem_we=1, mem_wdata=8'h77; completion shows writeReg_o=0.
REQ-034 LOAD then ADD held by in_valid during WAIT -> ADD accepted the cycle after completion, results in order, no duplicate.
REQ-035 rst_n pulsed low during WAIT -> mem_req=0 asynchronously, no out_valid after release, next op accepted normally.
REQ-036 With MEM_STAGE_TIMEOUT_EN, TIMEOUT=4, no mem_ack -> completion after 4 WAIT cycles with meDat_o=8'hFF, err=1 sticky.
